// File: rtl/snake_head_stepper.sv
// Snake head stepper: owns the game tick and moves the head one grid cell per tick,
// with toroidal wrap-around and rejection of 180-degree direction reversals.
module snake_head_stepper #(
  parameter int unsigned GRID_W      = 32,
  parameter int unsigned GRID_H      = 24,
  parameter int unsigned X_W         = 6,
  parameter int unsigned Y_W         = 5,
  parameter int unsigned TICK_CYCLES = 2500000,
  parameter int unsigned START_X     = 16,
  parameter int unsigned START_Y     = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     dir_i,
  input  logic           start_i,
  input  logic           pause_i,
  input  logic           stop_i,
  output logic [X_W-1:0] head_x_o,
  output logic [Y_W-1:0] head_y_o,
  output logic [1:0]     cur_dir_o,
  output logic           step_o,
  output logic           running_o
);

  localparam int unsigned CntW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CntW-1:0] TickLast = CntW'(TICK_CYCLES - 1);

  localparam logic [X_W-1:0] XMax   = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] YMax   = Y_W'(GRID_H - 1);
  localparam logic [X_W-1:0] XStart = X_W'(START_X);
  localparam logic [Y_W-1:0] YStart = Y_W'(START_Y);

  localparam logic [1:0] DirTop   = 2'b00;
  localparam logic [1:0] DirRight = 2'b01;
  localparam logic [1:0] DirDown  = 2'b10;
  localparam logic [1:0] DirLeft  = 2'b11;

  localparam logic [1:0] StIdle  = 2'b00;
  localparam logic [1:0] StRun   = 2'b01;
  localparam logic [1:0] StPause = 2'b10;

  logic [1:0]      state_q, state_d;
  logic [X_W-1:0]  x_q, x_d;
  logic [Y_W-1:0]  y_q, y_d;
  logic [1:0]      cur_dir_q, cur_dir_d;
  logic [1:0]      pend_dir_q, pend_dir_d;
  logic [CntW-1:0] tick_cnt_q, tick_cnt_d;
  logic            step_q, step_d;
  logic            running_q, running_d;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    cur_dir_d  = cur_dir_q;
    pend_dir_d = pend_dir_q;
    tick_cnt_d = tick_cnt_q;
    step_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d    = StRun;
          x_d        = XStart;
          y_d        = YStart;
          cur_dir_d  = DirTop;
          pend_dir_d = DirTop;
          tick_cnt_d = '0;
        end
      end
      StRun: begin
        // Reversal is judged against the committed direction, not the pending one.
        if ((dir_i != cur_dir_q) && ((dir_i ^ cur_dir_q) != 2'b10)) begin
          pend_dir_d = dir_i;
        end
        if (stop_i) begin
          state_d = StIdle;
        end else if (pause_i) begin
          state_d = StPause;
        end else if (tick_cnt_q == TickLast) begin
          tick_cnt_d = '0;
          cur_dir_d  = pend_dir_q;
          step_d     = 1'b1;
          case (pend_dir_q)
            DirTop:   y_d = (y_q == '0)   ? YMax : y_q - 1'b1;
            DirDown:  y_d = (y_q == YMax) ? '0   : y_q + 1'b1;
            DirLeft:  x_d = (x_q == '0)   ? XMax : x_q - 1'b1;
            DirRight: x_d = (x_q == XMax) ? '0   : x_q + 1'b1;
            default:  ;
          endcase
        end else begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end
      StPause: begin
        if (stop_i) begin
          state_d = StIdle;
        end else if (pause_i) begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase

    running_d = (state_d == StRun);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      x_q        <= XStart;
      y_q        <= YStart;
      cur_dir_q  <= DirTop;
      pend_dir_q <= DirTop;
      tick_cnt_q <= '0;
      step_q     <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      cur_dir_q  <= cur_dir_d;
      pend_dir_q <= pend_dir_d;
      tick_cnt_q <= tick_cnt_d;
      step_q     <= step_d;
      running_q  <= running_d;
    end
  end

  assign head_x_o  = x_q;
  assign head_y_o  = y_q;
  assign cur_dir_o = cur_dir_q;
  assign step_o    = step_q;
  assign running_o = running_q;

endmodule

// File: tb/tb_snake_head_stepper.sv
// Bench for snake_head_stepper: small grid, short tick, directed stimulus checked against
// a modulo-arithmetic game model every cycle plus hand-computed head positions.
module tb_snake_head_stepper;

  localparam int unsigned GW   = 8;
  localparam int unsigned GH   = 6;
  localparam int unsigned XW   = 4;
  localparam int unsigned YW   = 3;
  localparam int unsigned TICK = 4;
  localparam int unsigned SX   = 4;
  localparam int unsigned SY   = 3;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    dir   = 2'b00;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          stop  = 1'b0;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic [1:0]    cur_dir;
  logic          step;
  logic          running;

  int checks   = 0;
  int failures = 0;

  snake_head_stepper #(
    .GRID_W     (GW),
    .GRID_H     (GH),
    .X_W        (XW),
    .Y_W        (YW),
    .TICK_CYCLES(TICK),
    .START_X    (SX),
    .START_Y    (SY)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dir_i    (dir),
    .start_i  (start),
    .pause_i  (pause),
    .stop_i   (stop),
    .head_x_o (head_x),
    .head_y_o (head_y),
    .cur_dir_o(cur_dir),
    .step_o   (step),
    .running_o(running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: mode 0=idle, 1=run, 2=pause; positions as plain integers.
  int m_mode, m_x, m_y, m_cur, m_pend, m_cnt, m_step;

  always @(posedge clk or negedge rst_n) begin : model
    int nmode, nx, ny, ncur, npend, ncnt, nstep;
    if (!rst_n) begin
      m_mode <= 0;
      m_x    <= SX;
      m_y    <= SY;
      m_cur  <= 0;
      m_pend <= 0;
      m_cnt  <= 0;
      m_step <= 0;
    end else begin
      nmode = m_mode; nx = m_x; ny = m_y; ncur = m_cur; npend = m_pend; ncnt = m_cnt;
      nstep = 0;
      if (m_mode == 0) begin
        if (start) begin
          nmode = 1; nx = SX; ny = SY; ncur = 0; npend = 0; ncnt = 0;
        end
      end else if (m_mode == 1) begin
        if (int'(dir) != m_cur && (int'(dir) ^ m_cur) != 2) npend = int'(dir);
        if (stop) nmode = 0;
        else if (pause) nmode = 2;
        else if (m_cnt == TICK - 1) begin
          ncnt  = 0;
          ncur  = m_pend;
          nstep = 1;
          if (m_pend == 0) ny = (m_y + GH - 1) % GH;
          if (m_pend == 2) ny = (m_y + 1) % GH;
          if (m_pend == 3) nx = (m_x + GW - 1) % GW;
          if (m_pend == 1) nx = (m_x + 1) % GW;
        end else ncnt = m_cnt + 1;
      end else begin
        if (stop) nmode = 0;
        else if (pause) nmode = 1;
      end
      m_mode <= nmode; m_x <= nx; m_y <= ny; m_cur <= ncur; m_pend <= npend;
      m_cnt <= ncnt; m_step <= nstep;
    end
  end

  always @(negedge clk) begin
    chk("cmp_head_x", int'(head_x), m_x);
    chk("cmp_head_y", int'(head_y), m_y);
    chk("cmp_cur_dir", int'(cur_dir), m_cur);
    chk("cmp_step", int'(step), m_step);
    chk("cmp_running", int'(running), (m_mode == 1) ? 1 : 0);
  end

  task automatic expect_head(input string tag, input int x, input int y, input int d);
    chk({tag, "_x"}, int'(head_x), x);
    chk({tag, "_y"}, int'(head_y), y);
    chk({tag, "_dir"}, int'(cur_dir), d);
  endtask

  // Waits (bounded) for the next step pulse and checks the gap in cycles.
  task automatic wait_step(input string tag, input int exp_gap);
    int  n    = 0;
    bit  seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (step) seen = 1'b1;
    end
    chk({tag, "_gap"}, seen ? n : -1, exp_gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    expect_head("reset", 4, 3, 0);
    chk("reset_running", int'(running), 0);
    chk("reset_step", int'(step), 0);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    chk("start_running", int'(running), 1);

    // Upward run with wrap on y.
    wait_step("up1", 4); expect_head("up1", 4, 2, 0);
    wait_step("up2", 4); expect_head("up2", 4, 1, 0);
    wait_step("up3", 4); expect_head("up3", 4, 0, 0);
    wait_step("up4", 4); expect_head("up4", 4, 5, 0);

    // Reversal request is ignored.
    dir = 2'b10;
    wait_step("rev", 4); expect_head("rev", 4, 4, 0);

    // RIGHT then DOWN inside one period: RIGHT wins, DOWN accepted next tick.
    dir = 2'b01;
    @(negedge clk);
    dir = 2'b10;
    wait_step("turn1", 3); expect_head("turn1", 5, 4, 1);
    wait_step("turn2", 4); expect_head("turn2", 5, 5, 2);

    // x wrap to the right, y wrap downward, x wrap to the left.
    dir = 2'b01;
    wait_step("r1", 4); expect_head("r1", 6, 5, 1);
    wait_step("r2", 4); expect_head("r2", 7, 5, 1);
    wait_step("rwrap", 4); expect_head("rwrap", 0, 5, 1);
    dir = 2'b10;
    wait_step("dwrap", 4); expect_head("dwrap", 0, 0, 2);
    dir = 2'b11;
    wait_step("lwrap", 4); expect_head("lwrap", 7, 0, 3);

    // Pause with tick_cnt at 2, hold 10 cycles, resume.
    repeat (2) @(negedge clk);
    pause = 1'b1;
    @(negedge clk);
    pause = 1'b0;
    chk("paused_running", int'(running), 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("paused_step", int'(step), 0);
    end
    expect_head("paused", 7, 0, 3);
    pause = 1'b1;
    @(negedge clk);
    pause = 1'b0;
    chk("resume_running", int'(running), 1);
    wait_step("resume", 2); expect_head("resume", 6, 0, 3);

    // Stop on the terminal tick suppresses the move.
    repeat (3) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_step", int'(step), 0);
    chk("stop_running", int'(running), 0);
    expect_head("stop", 6, 0, 3);
    repeat (5) @(negedge clk);
    expect_head("stop_hold", 6, 0, 3);

    // Restart, then asynchronous reset mid-run.
    dir = 2'b00;
    pulse_start();
    wait_step("restart", 4); expect_head("restart", 4, 2, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    expect_head("async_rst", 4, 3, 0);
    chk("async_rst_running", int'(running), 0);
    chk("async_rst_step", int'(step), 0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
